// File: rtl/max7219_cascade_pkg.sv
// Shared types and helpers for the MAX7219 cascade command sequencer.
package max7219_cascade_pkg;

  // Sequencer FSM states
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RD_REQ    = 3'd1,
    RD_WAIT   = 3'd2,
    SEND      = 3'd3,
    WAIT_DONE = 3'd4,
    NEXT      = 3'd5,
    DELAY     = 3'd6
  } t_seq_state;

  // Largest supported daisy-chain length; sizes the device counter
  localparam int C_MAX_DEVICES = 16;

  // Ceiling log2, used at elaboration time for counter widths
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/max7219_cmd_ram.sv
// Read-first true dual-port command RAM: port A read/write for the host,
// port B read-only for the sequencer.
module max7219_cmd_ram #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_me,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_me,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  output logic [DATA_WIDTH-1:0] b_rdata
);

  localparam int C_DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [0:C_DEPTH-1];

  // Host writes; storage itself is never cleared by reset
  always_ff @(posedge clk) begin
    if (a_me && a_we) begin
      mem[a_addr] <= a_wdata;
    end
  end

  // Host read port, returns the pre-write contents on a same-address write
  always_ff @(posedge clk) begin
    if (rst) begin
      a_rdata <= '0;
    end else if (a_me) begin
      a_rdata <= mem[a_addr];
    end
  end

  // Sequencer read port, sees old data if the host writes the same address
  always_ff @(posedge clk) begin
    if (rst) begin
      b_rdata <= '0;
    end else if (b_me) begin
      b_rdata <= mem[b_addr];
    end
  end

endmodule

// File: rtl/max7219_cascade_cmd_decod.sv
// MAX7219 daisy-chain command sequencer: replays a window of the command RAM
// frame by frame towards the serial interface, strobing load on frame ends.
module max7219_cascade_cmd_decod
  import max7219_cascade_pkg::*;
#(
  parameter int G_RAM_ADDR_WIDTH = 8,
  parameter int G_RAM_DATA_WIDTH = 16,
  parameter int G_NB_DEVICES     = 4,
  parameter int G_DELAY_WIDTH    = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_en,
  input  logic                        i_me,
  input  logic                        i_we,
  input  logic [G_RAM_ADDR_WIDTH-1:0] i_addr,
  input  logic [G_RAM_DATA_WIDTH-1:0] i_wdata,
  output logic [G_RAM_DATA_WIDTH-1:0] o_rdata,
  input  logic [G_RAM_ADDR_WIDTH-1:0] i_start_ptr,
  input  logic [G_RAM_ADDR_WIDTH-1:0] i_last_ptr,
  input  logic                        i_ptrval,
  input  logic                        i_loop,
  input  logic [G_DELAY_WIDTH-1:0]    i_frame_delay,
  output logic                        o_ptr_equality,
  output logic                        o_busy,
  input  logic                        i_max7219_if_done,
  output logic                        o_max7219_if_start,
  output logic                        o_max7219_if_en_load,
  output logic [G_RAM_DATA_WIDTH-1:0] o_max7219_if_data
);

  localparam int C_DEV_W = clog2(C_MAX_DEVICES);
  localparam logic [C_DEV_W-1:0] C_LAST_DEV = C_DEV_W'(G_NB_DEVICES - 1);
  localparam logic [G_RAM_ADDR_WIDTH-1:0] C_PTR_ONE = G_RAM_ADDR_WIDTH'(1);
  localparam logic [G_DELAY_WIDTH-1:0] C_DLY_ONE = G_DELAY_WIDTH'(1);

  t_seq_state state_q, state_d;

  logic [G_RAM_ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [G_RAM_ADDR_WIDTH-1:0] first_q, first_d;
  logic [G_RAM_ADDR_WIDTH-1:0] last_q, last_d;
  logic [C_DEV_W-1:0]          dev_cnt_q, dev_cnt_d;
  logic [G_DELAY_WIDTH-1:0]    delay_cnt_q, delay_cnt_d;
  logic                        busy_q;
  logic                        start_q, start_d;
  logic                        en_load_q, en_load_d;
  logic [G_RAM_DATA_WIDTH-1:0] data_q, data_d;
  logic                        eq_q, eq_d;
  logic                        abort_q, abort_d;

  logic                        ram_b_me;
  logic [G_RAM_DATA_WIDTH-1:0] ram_b_rdata;

  max7219_cmd_ram #(
    .ADDR_WIDTH (G_RAM_ADDR_WIDTH),
    .DATA_WIDTH (G_RAM_DATA_WIDTH)
  ) u_cmd_ram (
    .clk     (clk),
    .rst     (rst),
    .a_me    (i_me),
    .a_we    (i_we),
    .a_addr  (i_addr),
    .a_wdata (i_wdata),
    .a_rdata (o_rdata),
    .b_me    (ram_b_me),
    .b_addr  (ptr_q),
    .b_rdata (ram_b_rdata)
  );

  // Next-state and datapath decisions; a disable request is remembered so a
  // short i_en drop still stops the sequence once the current word completes
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    first_d     = first_q;
    last_d      = last_q;
    dev_cnt_d   = dev_cnt_q;
    delay_cnt_d = delay_cnt_q;
    start_d     = 1'b0;
    en_load_d   = en_load_q;
    data_d      = data_q;
    eq_d        = 1'b0;
    abort_d     = abort_q;
    ram_b_me    = 1'b0;

    if ((state_q != IDLE) && !i_en) begin
      abort_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        abort_d = 1'b0;
        if (i_ptrval && i_en) begin
          first_d   = i_start_ptr;
          last_d    = i_last_ptr;
          ptr_d     = i_start_ptr;
          dev_cnt_d = '0;
          state_d   = RD_REQ;
        end
      end

      RD_REQ: begin
        ram_b_me = 1'b1;
        state_d  = RD_WAIT;
      end

      RD_WAIT: begin
        start_d   = 1'b1;
        data_d    = ram_b_rdata;
        en_load_d = (dev_cnt_q == C_LAST_DEV) || (ptr_q == last_q);
        state_d   = SEND;
      end

      SEND: begin
        state_d = WAIT_DONE;
      end

      WAIT_DONE: begin
        if (i_max7219_if_done) begin
          state_d = NEXT;
        end
      end

      NEXT: begin
        eq_d = (ptr_q == last_q);
        if (abort_q || !i_en) begin
          state_d = IDLE;
        end else if (en_load_q) begin
          dev_cnt_d = '0;
          if (ptr_q == last_q) begin
            if (i_loop) begin
              ptr_d       = first_q;
              delay_cnt_d = i_frame_delay;
              state_d     = DELAY;
            end else begin
              state_d = IDLE;
            end
          end else begin
            ptr_d       = ptr_q + C_PTR_ONE;
            delay_cnt_d = i_frame_delay;
            state_d     = DELAY;
          end
        end else begin
          dev_cnt_d = dev_cnt_q + C_DEV_W'(1);
          ptr_d     = ptr_q + C_PTR_ONE;
          state_d   = RD_REQ;
        end
      end

      DELAY: begin
        if (abort_q || !i_en) begin
          state_d = IDLE;
        end else if (delay_cnt_q <= C_DLY_ONE) begin
          state_d = RD_REQ;
        end else begin
          delay_cnt_d = delay_cnt_q - C_DLY_ONE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset clears everything except RAM storage
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      first_q     <= '0;
      last_q      <= '0;
      dev_cnt_q   <= '0;
      delay_cnt_q <= '0;
      busy_q      <= 1'b0;
      start_q     <= 1'b0;
      en_load_q   <= 1'b0;
      data_q      <= '0;
      eq_q        <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      first_q     <= first_d;
      last_q      <= last_d;
      dev_cnt_q   <= dev_cnt_d;
      delay_cnt_q <= delay_cnt_d;
      busy_q      <= (state_d != IDLE);
      start_q     <= start_d;
      en_load_q   <= en_load_d;
      data_q      <= data_d;
      eq_q        <= eq_d;
      abort_q     <= abort_d;
    end
  end

  assign o_busy               = busy_q;
  assign o_max7219_if_start   = start_q;
  assign o_max7219_if_en_load = en_load_q;
  assign o_max7219_if_data    = data_q;
  assign o_ptr_equality       = eq_q;

endmodule

// File: tb/tb_max7219_cascade_cmd_decod.sv
// Self-checking bench for the MAX7219 cascade command sequencer.
module tb_max7219_cascade_cmd_decod;

  localparam int AW  = 8;
  localparam int DW  = 16;
  localparam int NB  = 4;
  localparam int DLW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_en;
  logic          i_me;
  logic          i_we;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_wdata;
  logic [DW-1:0] o_rdata;
  logic [AW-1:0] i_start_ptr;
  logic [AW-1:0] i_last_ptr;
  logic          i_ptrval;
  logic          i_loop;
  logic [DLW-1:0] i_frame_delay;
  logic          o_ptr_equality;
  logic          o_busy;
  logic          i_max7219_if_done;
  logic          o_max7219_if_start;
  logic          o_max7219_if_en_load;
  logic [DW-1:0] o_max7219_if_data;

  max7219_cascade_cmd_decod #(
    .G_RAM_ADDR_WIDTH (AW),
    .G_RAM_DATA_WIDTH (DW),
    .G_NB_DEVICES     (NB),
    .G_DELAY_WIDTH    (DLW)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .i_en                 (i_en),
    .i_me                 (i_me),
    .i_we                 (i_we),
    .i_addr               (i_addr),
    .i_wdata              (i_wdata),
    .o_rdata              (o_rdata),
    .i_start_ptr          (i_start_ptr),
    .i_last_ptr           (i_last_ptr),
    .i_ptrval             (i_ptrval),
    .i_loop               (i_loop),
    .i_frame_delay        (i_frame_delay),
    .o_ptr_equality       (o_ptr_equality),
    .o_busy               (o_busy),
    .i_max7219_if_done    (i_max7219_if_done),
    .o_max7219_if_start   (o_max7219_if_start),
    .o_max7219_if_en_load (o_max7219_if_en_load),
    .o_max7219_if_data    (o_max7219_if_data)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic          load;
  } exp_word_t;

  typedef struct {
    string          name;
    logic [AW-1:0]  sp;
    logic [AW-1:0]  lp;
    logic [DLW-1:0] delay;
    int             n_words;
    logic [15:0]    load_mask;
    int             exp_eq;
  } seq_vec_t;

  int vec_cnt     = 0;
  int miscompares = 0;

  exp_word_t     sb[$];
  logic [DW-1:0] mem_model [0:255];

  int   cyc       = 0;
  int   start_cnt = 0;
  int   eq_cnt    = 0;
  int   done_cnt  = 0;
  int   done_lat  = 10;
  int   done_cyc  = 0;
  int   min_gap   = 1000;
  int   max_gap   = 0;
  logic last_load = 1'b0;
  logic prev_start = 1'b0;
  logic gap_armed = 1'b0;

  seq_vec_t vecs [5];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vec_cnt = vec_cnt + 1;
    if (actual !== expected) begin
      miscompares = miscompares + 1;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Serial-interface model and scoreboard consumer: every start pulse is
  // compared against the queue head, and done returns done_lat cycles later
  initial begin
    exp_word_t e;
    i_max7219_if_done = 1'b0;
    forever begin
      @(negedge clk);
      cyc = cyc + 1;
      i_max7219_if_done = 1'b0;
      if (done_cnt > 0) begin
        done_cnt = done_cnt - 1;
        if (done_cnt == 0) begin
          i_max7219_if_done = 1'b1;
          if (last_load) begin
            gap_armed = 1'b1;
            done_cyc  = cyc;
          end
        end
      end
      if (o_ptr_equality) eq_cnt = eq_cnt + 1;
      if (o_max7219_if_start) begin
        start_cnt = start_cnt + 1;
        checkOutput("start_single_cycle", {31'd0, prev_start}, 32'd0);
        checkOutput("start_expected", (sb.size() != 0) ? 32'd1 : 32'd0, 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          checkOutput("word_data", {16'd0, o_max7219_if_data}, {16'd0, e.data});
          checkOutput("word_en_load", {31'd0, o_max7219_if_en_load}, {31'd0, e.load});
        end
        if (gap_armed) begin
          if ((cyc - done_cyc) < min_gap) min_gap = cyc - done_cyc;
          if ((cyc - done_cyc) > max_gap) max_gap = cyc - done_cyc;
          gap_armed = 1'b0;
        end
        done_cnt  = done_lat;
        last_load = o_max7219_if_en_load;
      end
      prev_start = o_max7219_if_start;
    end
  end

  task automatic hostWrite(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    @(negedge clk);
    i_me = 1'b1; i_we = 1'b1; i_addr = addr; i_wdata = data;
    @(negedge clk);
    i_me = 1'b0; i_we = 1'b0;
    mem_model[addr] = data;
  endtask

  task automatic hostRead(input logic [AW-1:0] addr, input string name);
    @(negedge clk);
    i_me = 1'b1; i_we = 1'b0; i_addr = addr;
    @(negedge clk);
    i_me = 1'b0;
    checkOutput(name, {16'd0, o_rdata}, {16'd0, mem_model[addr]});
  endtask

  task automatic pulsePtrval(input logic [AW-1:0] sp, input logic [AW-1:0] lp,
                             input logic [DLW-1:0] delay);
    @(negedge clk);
    i_start_ptr = sp; i_last_ptr = lp; i_frame_delay = delay; i_ptrval = 1'b1;
    @(negedge clk);
    i_ptrval = 1'b0;
  endtask

  task automatic waitIdle(input string name);
    int n;
    n = 0;
    while (o_busy && n < 4000) begin
      @(negedge clk);
      n = n + 1;
    end
    checkOutput({name, "_idle_timeout"}, (n < 4000) ? 32'd1 : 32'd0, 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic waitStarts(input int target, input string name);
    int n;
    n = 0;
    while (start_cnt < target && n < 2000) begin
      @(negedge clk);
      n = n + 1;
    end
    checkOutput({name, "_start_timeout"}, (n < 2000) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic applyStimulus(input seq_vec_t v);
    exp_word_t e;
    int st0, eq0;
    for (int k = 0; k < v.n_words; k++) begin
      e.data = mem_model[8'(int'(v.sp) + k)];
      e.load = v.load_mask[k];
      sb.push_back(e);
    end
    st0 = start_cnt;
    eq0 = eq_cnt;
    pulsePtrval(v.sp, v.lp, v.delay);
    checkOutput({v.name, "_busy_rise"}, {31'd0, o_busy}, 32'd1);
    waitIdle(v.name);
    checkOutput({v.name, "_starts"}, start_cnt - st0, v.n_words);
    checkOutput({v.name, "_eq_pulses"}, eq_cnt - eq0, v.exp_eq);
    checkOutput({v.name, "_sb_drained"}, sb.size(), 32'd0);
    checkOutput({v.name, "_busy_fall"}, {31'd0, o_busy}, 32'd0);
  endtask

  task automatic checkAllZero(input string name);
    checkOutput({name, "_start"}, {31'd0, o_max7219_if_start}, 32'd0);
    checkOutput({name, "_en_load"}, {31'd0, o_max7219_if_en_load}, 32'd0);
    checkOutput({name, "_data"}, {16'd0, o_max7219_if_data}, 32'd0);
    checkOutput({name, "_busy"}, {31'd0, o_busy}, 32'd0);
    checkOutput({name, "_eq"}, {31'd0, o_ptr_equality}, 32'd0);
    checkOutput({name, "_rdata"}, {16'd0, o_rdata}, 32'd0);
  endtask

  initial begin
    exp_word_t e;
    int st0, eq0, n;
    logic [7:0] a8;

    vecs[0] = '{"basic",   8'h00, 8'h03, 32'd0, 4, 16'h0008, 1};
    vecs[1] = '{"wrap",    8'hFE, 8'h01, 32'd2, 4, 16'h0008, 1};
    vecs[2] = '{"partial", 8'h00, 8'h05, 32'd0, 6, 16'h0028, 1};
    vecs[3] = '{"single",  8'h40, 8'h40, 32'd0, 1, 16'h0001, 1};
    vecs[4] = '{"nine",    8'h80, 8'h88, 32'd3, 9, 16'h0188, 1};

    rst = 1'b1; i_en = 1'b1; i_me = 1'b0; i_we = 1'b0; i_addr = '0; i_wdata = '0;
    i_start_ptr = '0; i_last_ptr = '0; i_ptrval = 1'b0; i_loop = 1'b0; i_frame_delay = '0;

    repeat (3) @(negedge clk);
    checkAllZero("reset_state");
    rst = 1'b0;

    $display("[TB] filling command RAM");
    for (int a = 0; a < 256; a++) begin
      a8 = 8'(a);
      hostWrite(a8, (a < 4) ? 16'h0C01 : {a8 ^ 8'h5A, a8});
    end
    hostRead(8'h07, "host_read_07");
    hostRead(8'hFE, "host_read_FE");

    $display("[TB] table-driven sequences");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i]);
    end

    $display("[TB] looping sequence");
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < 8; k++) begin
        e.data = mem_model[8'(16 + k)];
        e.load = (k == 3) || (k == 7);
        sb.push_back(e);
      end
    end
    st0 = start_cnt; eq0 = eq_cnt;
    gap_armed = 1'b0; min_gap = 1000; max_gap = 0;
    i_loop = 1'b1;
    pulsePtrval(8'h10, 8'h17, 32'd5);
    n = 0;
    while (eq_cnt < eq0 + 2 && n < 3000) begin
      @(negedge clk);
      n = n + 1;
    end
    checkOutput("loop_two_passes", (n < 3000) ? 32'd1 : 32'd0, 32'd1);
    i_loop = 1'b0;
    waitIdle("loop");
    checkOutput("loop_starts", start_cnt - st0, 32'd24);
    checkOutput("loop_eq_pulses", eq_cnt - eq0, 32'd3);
    checkOutput("loop_sb_drained", sb.size(), 32'd0);
    checkOutput("loop_min_gap", min_gap, 32'd9);
    checkOutput("loop_max_gap", max_gap, 32'd9);

    $display("[TB] enable drop mid-sequence");
    e.data = mem_model[8'h00]; e.load = 1'b0;
    sb.push_back(e);
    st0 = start_cnt; eq0 = eq_cnt;
    pulsePtrval(8'h00, 8'h03, 32'd0);
    waitStarts(st0 + 1, "en_drop");
    pulsePtrval(8'h40, 8'h40, 32'd0);
    i_en = 1'b0;
    waitIdle("en_drop");
    repeat (20) @(negedge clk);
    checkOutput("en_drop_starts", start_cnt - st0, 32'd1);
    checkOutput("en_drop_eq_pulses", eq_cnt - eq0, 32'd0);
    checkOutput("en_drop_busy", {31'd0, o_busy}, 32'd0);
    checkOutput("en_drop_sb_drained", sb.size(), 32'd0);
    i_en = 1'b1;

    $display("[TB] reset mid-sequence");
    hostRead(8'h01, "host_read_01");
    e.data = mem_model[8'h00]; e.load = 1'b0;
    sb.push_back(e);
    st0 = start_cnt;
    pulsePtrval(8'h00, 8'h03, 32'd0);
    waitStarts(st0 + 1, "mid_reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkAllZero("mid_reset");
    rst = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("mid_reset_no_restart", start_cnt - st0, 32'd1);
    checkOutput("mid_reset_busy", {31'd0, o_busy}, 32'd0);
    checkOutput("mid_reset_sb_drained", sb.size(), 32'd0);

    $display("[TB] host port write/read");
    hostWrite(8'h20, 16'hBEEF);
    hostRead(8'h20, "host_beef");
    @(negedge clk);
    i_me = 1'b1; i_we = 1'b1; i_addr = 8'h20; i_wdata = 16'h1234;
    @(negedge clk);
    i_me = 1'b0; i_we = 1'b0;
    checkOutput("host_read_first", {16'd0, o_rdata}, 32'h0000BEEF);
    mem_model[8'h20] = 16'h1234;
    hostRead(8'h20, "host_after_write");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
    $finish;
  end

endmodule
